node_chain_sched: RTL

- Sequencer for a chain of tree-parser compute nodes that share the ST/RD/RES handshake.
- One top-level start runs child stages 0..NSTAGE-1 in strict order. Each child gets a one-cycle ST pulse, and the block waits for that child's RD to go low and then high again.
- Results are captured per stage. The final stage result is presented on RES with a top-level RD/ERR status.
- Sits between the tree root and its per-level node instances.

---
 rtl/node_chain_sched_if.sv | 57 +++++
 rtl/node_chain_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/node_chain_sched_if.sv
// node_chain_sched_if
//   Bundles the sequencer's top-level handshake (ST/RD/RES/ERR/STAGE) and the
//   fan-out bus to the child compute nodes (CH_ST/CH_RD/CH_RES).
//
//   Modports:
//     slave  - the sequencer itself: takes ST and the child status, drives
//              RD/RES/ERR/STAGE and the per-child start pulses.
//     master - the environment around it (tree root plus the child nodes).
//
//   Optional: when NODE_SCHED_SKIP_EN is defined an extra SKIP[NSTAGE-1:0]
//   input is present; set bits mark stages that must not be started.
`timescale 1ns/1ps

interface node_chain_sched_if #(
  parameter int NSTAGE = 4,
  parameter int W      = 16
);
  logic                  ST;
  logic                  RD;
  logic [W-1:0]          RES;
  logic                  ERR;
  logic [3:0]            STAGE;
  logic [NSTAGE-1:0]     CH_ST;
  logic [NSTAGE-1:0]     CH_RD;
  logic [NSTAGE*W-1:0]   CH_RES;
`ifdef NODE_SCHED_SKIP_EN
  logic [NSTAGE-1:0]     SKIP;
`endif

  modport slave (
    input  ST,
    input  CH_RD,
    input  CH_RES,
`ifdef NODE_SCHED_SKIP_EN
    input  SKIP,
`endif
    output RD,
    output RES,
    output ERR,
    output STAGE,
    output CH_ST
  );

  modport master (
    output ST,
    output CH_RD,
    output CH_RES,
`ifdef NODE_SCHED_SKIP_EN
    output SKIP,
`endif
    input  RD,
    input  RES,
    input  ERR,
    input  STAGE,
    input  CH_ST
  );
endinterface

// File: rtl/node_chain_sched.sv
// node_chain_sched
//   Runs a chain of child compute nodes in strict index order after a rising
//   edge on ST. Each child gets a one-cycle CH_ST pulse; the sequencer then
//   waits for that child's CH_RD to drop (acknowledge) and rise again
//   (completion), captures its result slice, and immediately starts the next
//   child. The final captured result sits on RES; RD returns high when the
//   chain ends. A per-stage cycle limit (TMO) aborts the run with ERR set.
//
//   Ports:
//     CLK        clock, all state on the rising edge
//     RST        asynchronous active-low reset
//     bus.ST     top-level start (rising edge triggers a run)
//     bus.RD     top-level ready, low while a run is in progress
//     bus.RES    result of the last completed stage
//     bus.ERR    timeout flag for the last run
//     bus.STAGE  index of the stage being run (holds when idle)
//     bus.CH_ST  one-hot, one-cycle child start pulses
//     bus.CH_RD  child ready (idle high, low while busy)
//     bus.CH_RES child results, stage k in bits [k*W +: W]
//
//   Build option NODE_SCHED_SKIP_EN: adds bus.SKIP; bits set at the start edge
//   are latched for the run and those stages are never started.
`timescale 1ns/1ps

module node_chain_sched #(
  parameter int NSTAGE = 4,
  parameter int W      = 16,
  parameter int TMO    = 255
) (
  input  logic CLK,
  input  logic RST,
  node_chain_sched_if.slave bus
);

  localparam int          SW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [15:0] TMO_L = 16'(TMO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic              st_q_reg;
  logic              rd_reg;
  logic              err_reg;
  logic [W-1:0]      res_reg;
  logic [3:0]        stage_reg;
  logic [NSTAGE-1:0] ch_st_reg;
  logic [15:0]       cnt_reg;

  // Result slices laid out as an array so the active one can be muxed out.
  logic [W-1:0] res_slice [NSTAGE];
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_slice
      assign res_slice[gi] = bus.CH_RES[gi*W +: W];
    end
  endgenerate

  logic [SW-1:0] stage_idx;
  logic          cur_rd;
  logic [W-1:0]  cur_res;
  logic [15:0]   cnt_next;
  logic          timeout;
  logic          start_edge;

  assign stage_idx  = stage_reg[SW-1:0];
  assign cur_rd     = bus.CH_RD[stage_idx];
  assign cur_res    = res_slice[stage_idx];
  assign cnt_next   = cnt_reg + 16'd1;
  // The counter "reaches" TMO on the edge where it would become TMO, so the
  // abort lands exactly TMO cycles after the stage's CH_ST assertion.
  assign timeout    = (cnt_next == TMO_L);
  assign start_edge = bus.ST & ~st_q_reg;

  // Skip masks: the live input is used to pick the first stage on the start
  // edge; the latched copy steers the remainder of the run.
  logic [NSTAGE-1:0] skip_in;
  logic [NSTAGE-1:0] skip_run;
`ifdef NODE_SCHED_SKIP_EN
  logic [NSTAGE-1:0] skip_reg;
  assign skip_in  = bus.SKIP;
  assign skip_run = skip_reg;
`else
  assign skip_in  = '0;
  assign skip_run = '0;
`endif

  // Lowest unskipped stage, and lowest unskipped stage above the current one.
  logic       first_found;
  logic [3:0] first_idx;
  logic       next_found;
  logic [3:0] next_idx;

  always_comb begin
    first_found = 1'b0;
    first_idx   = 4'd0;
    next_found  = 1'b0;
    next_idx    = 4'd0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (!skip_in[i]) begin
        first_found = 1'b1;
        first_idx   = 4'(i);
      end
      if (!skip_run[i] && (i > int'(stage_reg))) begin
        next_found = 1'b1;
        next_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      st_q_reg  <= 1'b0;
      rd_reg    <= 1'b1;
      err_reg   <= 1'b0;
      res_reg   <= '0;
      stage_reg <= 4'd0;
      ch_st_reg <= '0;
      cnt_reg   <= 16'd0;
`ifdef NODE_SCHED_SKIP_EN
      skip_reg  <= '0;
`endif
    end else begin
      st_q_reg <= bus.ST;
      case (state_reg)
        IDLE: begin
          ch_st_reg <= '0;
          if (start_edge) begin
            err_reg <= 1'b0;
`ifdef NODE_SCHED_SKIP_EN
            skip_reg <= bus.SKIP;
`endif
            // With every stage skipped nothing starts and RD stays high.
            if (first_found) begin
              rd_reg    <= 1'b0;
              stage_reg <= first_idx;
              ch_st_reg <= NSTAGE'(1) << first_idx;
              cnt_reg   <= 16'd0;
              state_reg <= ACK;
            end
          end
        end

        ACK: begin
          ch_st_reg <= '0;
          cnt_reg   <= cnt_next;
          if (timeout) begin
            err_reg   <= 1'b1;
            rd_reg    <= 1'b1;
            state_reg <= IDLE;
          end else if (!cur_rd) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          ch_st_reg <= '0;
          cnt_reg   <= cnt_next;
          // Timeout is checked first so a completion on the same edge loses.
          if (timeout) begin
            err_reg   <= 1'b1;
            rd_reg    <= 1'b1;
            state_reg <= IDLE;
          end else if (cur_rd) begin
            res_reg <= cur_res;
            if (!next_found) begin
              rd_reg    <= 1'b1;
              state_reg <= IDLE;
            end else begin
              stage_reg <= next_idx;
              ch_st_reg <= NSTAGE'(1) << next_idx;
              cnt_reg   <= 16'd0;
              state_reg <= ACK;
            end
          end
        end

        default: begin
          ch_st_reg <= '0;
          rd_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.RD    = rd_reg;
  assign bus.ERR   = err_reg;
  assign bus.RES   = res_reg;
  assign bus.STAGE = stage_reg;
  assign bus.CH_ST = ch_st_reg;

endmodule
